rotary_encoder_decoder: RTL and testbench
=========================================

ROTARY_ENCODER_DECODER -- requirements
Module: rotary_encoder_decoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CLK_CYCLES, default 4, meaning consecutive stable cycles required before a synchronized input is accepted (legal range 1..65535).
REQ-002 SHALL have parameter STEPS_PER_DETENT, default 4, meaning valid quadrature transitions per emitted rotation pulse (legal values 1, 2, 4).
REQ-003 SHALL have port i_Clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port i_Rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_Enc_A  input  1  raw encoder channel A, asynchronous, idle high.
REQ-006 SHALL have port i_Enc_B  input  1  raw encoder channel B, asynchronous, idle high.
REQ-007 SHALL have port i_Enc_Sw  input  1  raw push switch, asynchronous, active-low (0 = pressed).
REQ-008 SHALL have port o_Encoder_Btn  output  1  one-cycle pulse per accepted press.
REQ-009 SHALL have port o_Encoder_Left  output  1  one-cycle pulse per counter-clockwise detent.
REQ-010 SHALL have port o_Encoder_Right  output  1  one-cycle pulse per clockwise detent.
REQ-011 SHALL have port o_Error  output  1  one-cycle pulse per illegal quadrature transition (both channels changed).

Function
REQ-012 SHALL pass each of A, B, Sw through a dedicated two-flop synchronizer before any other use.
REQ-013 SHALL debounce each synchronized input independently: per-input counter clears when synchronized value equals filtered value; increments while different; when it reaches DEBOUNCE_CLK_CYCLES-1 with value still different, filtered value takes synchronized value and counter clears.
REQ-014 SHALL discard any glitch shorter than DEBOUNCE_CLK_CYCLES cycles (counter clears on return to filtered value).
REQ-015 SHALL register previous filtered {A,B} and compare with current filtered {A,B} every cycle.
REQ-016 SHALL treat transitions 11->10, 10->00, 00->01, 01->11 as clockwise (+1) and the reverse four as counter-clockwise (-1).
REQ-017 SHALL treat 11<->00 and 10<->01 as illegal: accumulator unchanged, o_Error pulsed, no rotation pulse.
REQ-018 SHALL keep a signed step accumulator (4 bits sufficient); on reaching +STEPS_PER_DETENT assert o_Encoder_Right and clear it; on reaching -STEPS_PER_DETENT assert o_Encoder_Left and clear it.
REQ-019 SHALL let direction reversal mid-detent simply decrement/increment the accumulator (e.g. +2 then -2 -> 0, no pulse).
REQ-020 SHALL assert o_Encoder_Btn for one cycle on filtered Sw 1->0 only; release (0->1) produces no pulse.
REQ-021 SHALL register all outputs; each pulse exactly one cycle; o_Encoder_Left and o_Encoder_Right never high together.
REQ-022 SHALL allow o_Encoder_Btn to coincide with a rotation or error pulse (independent paths).
REQ-023 SHALL produce a pulse after exactly DEBOUNCE_CLK_CYCLES+3 rising edges counted from the first edge sampling the new raw level (edge 1), given the triggering change completes a detent or press.

Reset
REQ-024 SHALL, when i_Rst is high at a rising edge, set synchronizer flops and filtered values to 1 (A, B, Sw), previous {A,B} to 11, counters and accumulator to 0, all outputs to 0.
REQ-025 SHALL, on reset asserted mid-detent or mid-debounce, abandon partial progress; no pulse emitted in the cycle after reset.
REQ-026 SHALL begin sampling inputs at the first rising edge with i_Rst low.

Verification
REQ-027 SHALL cover: DEBOUNCE=4, STEPS=4, raw AB 11->10->00->01->11, each held 10 cycles -> exactly one o_Encoder_Right pulse, 7 edges after the final 01->11 raw change, no Left/Error.
REQ-028 SHALL cover: reverse sequence 11->01->00->10->11 -> exactly one o_Encoder_Left pulse; then 11->10->00->10->11 -> no pulses, accumulator returns to 0.
REQ-029 SHALL cover: Sw low for 3 cycles then high (glitch) -> no pulse; Sw low 20 cycles -> one o_Encoder_Btn pulse 7 edges after the fall, none on release.
REQ-030 SHALL cover: raw AB 11->00 held 10 cycles -> one o_Error pulse, no rotation pulse.
REQ-031 SHALL cover: i_Rst high for one cycle after raw 11->10->00 -> all outputs 0; subsequent 00->01->11 yields no pulse (filtered reset to 11, partial progress lost).
REQ-032 SHALL cover: Sw press and final clockwise step filtered in same cycle -> o_Encoder_Btn and o_Encoder_Right high in the same cycle.

Source files
------------

// File: rtl/rotary_encoder_decoder.sv
// Quadrature rotary encoder decoder with push switch: synchronizes and debounces the raw
// channels, then emits one-cycle detent, press and illegal-transition pulses.
module rotary_encoder_decoder #(
  parameter int unsigned DEBOUNCE_CLK_CYCLES = 4,
  parameter int unsigned STEPS_PER_DETENT    = 4
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Enc_A,
  input  logic i_Enc_B,
  input  logic i_Enc_Sw,
  output logic o_Encoder_Btn,
  output logic o_Encoder_Left,
  output logic o_Encoder_Right,
  output logic o_Error
);

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_CW,
    STEP_CCW,
    STEP_ILLEGAL
  } step_e;

  localparam logic [15:0]       CNT_MAX  = 16'(DEBOUNCE_CLK_CYCLES - 1);
  localparam logic signed [3:0] STEP_LIM = 4'(STEPS_PER_DETENT);

  // Bit 2 = A, bit 1 = B, bit 0 = Sw throughout.
  logic [2:0]       raw;
  logic [2:0]       sync1_q, sync2_q;
  logic [2:0]       filt_q, filt_d;
  logic [2:0][15:0] cnt_q, cnt_d;
  logic [1:0]       prev_ab_q;
  logic             prev_sw_q;
  logic signed [3:0] acc_q, acc_d, acc_inc, acc_dec;
  logic             btn_q, left_q, right_q, err_q;
  logic             btn_d, left_d, right_d, err_d;
  step_e            step;

  assign raw = {i_Enc_A, i_Enc_B, i_Enc_Sw};

  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int unsigned i = 0; i < 3; i++) begin
      if (sync2_q[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        filt_d[i] = sync2_q[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  // Gray order 11 -> 10 -> 00 -> 01 -> 11 is clockwise; a double-bit change is illegal.
  always_comb begin
    unique case ({prev_ab_q, filt_q[2:1]})
      4'b11_10, 4'b10_00, 4'b00_01, 4'b01_11: step = STEP_CW;
      4'b10_11, 4'b00_10, 4'b01_00, 4'b11_01: step = STEP_CCW;
      4'b11_00, 4'b00_11, 4'b10_01, 4'b01_10: step = STEP_ILLEGAL;
      default:                                step = STEP_NONE;
    endcase
  end

  assign acc_inc = acc_q + 4'sd1;
  assign acc_dec = acc_q - 4'sd1;

  always_comb begin
    acc_d   = acc_q;
    left_d  = 1'b0;
    right_d = 1'b0;
    err_d   = 1'b0;
    btn_d   = prev_sw_q & ~filt_q[0];
    case (step)
      STEP_CW: begin
        if (acc_inc == STEP_LIM) begin
          right_d = 1'b1;
          acc_d   = '0;
        end else begin
          acc_d = acc_inc;
        end
      end
      STEP_CCW: begin
        if (acc_dec == -STEP_LIM) begin
          left_d = 1'b1;
          acc_d  = '0;
        end else begin
          acc_d = acc_dec;
        end
      end
      STEP_ILLEGAL: err_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      filt_q    <= '1;
      cnt_q     <= '0;
      prev_ab_q <= 2'b11;
      prev_sw_q <= 1'b1;
      acc_q     <= '0;
      btn_q     <= 1'b0;
      left_q    <= 1'b0;
      right_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      filt_q    <= filt_d;
      cnt_q     <= cnt_d;
      prev_ab_q <= filt_q[2:1];
      prev_sw_q <= filt_q[0];
      acc_q     <= acc_d;
      btn_q     <= btn_d;
      left_q    <= left_d;
      right_q   <= right_d;
      err_q     <= err_d;
    end
  end

  assign o_Encoder_Btn   = btn_q;
  assign o_Encoder_Left  = left_q;
  assign o_Encoder_Right = right_q;
  assign o_Error         = err_q;

endmodule

// File: tb/tb_rotary_encoder_decoder.sv
// Self-checking bench: directed scenarios plus random stimulus against a behavioural model
// that tracks encoder position as a Gray-code index and debounce as run lengths.
module tb_rotary_encoder_decoder;

  localparam int D = 4;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst, a, b, sw;
  logic btn, left, right, err;

  int checks = 0;
  int failures = 0;
  int edge_no = 0;

  // Behavioural model state (index 0 = A, 1 = B, 2 = Sw)
  bit m_s1[3], m_s2[3], m_f[3];
  int m_run[3];
  bit m_pa, m_pb, m_psw;
  int m_acc;
  bit e_btn, e_left, e_right, e_err;

  // Pulse tallies for directed scenarios
  int n_btn, n_left, n_right, n_err, n_both;
  int last_btn, last_right;

  always #5 clk = ~clk;

  rotary_encoder_decoder #(
    .DEBOUNCE_CLK_CYCLES(D),
    .STEPS_PER_DETENT   (S)
  ) dut (
    .i_Clk          (clk),
    .i_Rst          (rst),
    .i_Enc_A        (a),
    .i_Enc_B        (b),
    .i_Enc_Sw       (sw),
    .o_Encoder_Btn  (btn),
    .o_Encoder_Left (left),
    .o_Encoder_Right(right),
    .o_Error        (err)
  );

  function automatic int gray_pos(bit pa, bit pb);
    case ({pa, pb})
      2'b11:   return 0;
      2'b10:   return 1;
      2'b00:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s at edge %0d: got %b expected %b", tag, edge_no, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_tallies();
    n_btn = 0; n_left = 0; n_right = 0; n_err = 0; n_both = 0;
    last_btn = -1; last_right = -1;
  endtask

  task automatic tick();
    int d;
    @(posedge clk);
    edge_no++;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_s1[i] = 1; m_s2[i] = 1; m_f[i] = 1; m_run[i] = 0;
      end
      m_pa = 1; m_pb = 1; m_psw = 1; m_acc = 0;
      e_btn = 0; e_left = 0; e_right = 0; e_err = 0;
    end else begin
      e_btn = 0; e_left = 0; e_right = 0; e_err = 0;
      d = (gray_pos(m_f[0], m_f[1]) - gray_pos(m_pa, m_pb) + 4) % 4;
      if (d == 1) m_acc++;
      else if (d == 3) m_acc--;
      else if (d == 2) e_err = 1;
      if (m_acc == S) begin e_right = 1; m_acc = 0; end
      if (m_acc == -S) begin e_left = 1; m_acc = 0; end
      e_btn = m_psw && !m_f[2];
      m_pa = m_f[0]; m_pb = m_f[1]; m_psw = m_f[2];
      for (int i = 0; i < 3; i++) begin
        if (m_s2[i] != m_f[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin
            m_f[i] = m_s2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1[0] = a; m_s1[1] = b; m_s1[2] = sw;
    end
    #1;
    check("btn", btn, e_btn);
    check("left", left, e_left);
    check("right", right, e_right);
    check("error", err, e_err);
    check("left_right_exclusive", left & right, 1'b0);
    if (btn) begin n_btn++; last_btn = edge_no; end
    if (left) n_left++;
    if (right) begin n_right++; last_right = edge_no; end
    if (err) n_err++;
    if (btn && right) n_both++;
  endtask

  task automatic drive(input logic na, input logic nb, input logic nsw, input int cycles);
    a = na; b = nb; sw = nsw;
    repeat (cycles) tick();
  endtask

  int mark;

  initial begin
    rst = 1'b1; a = 1'b1; b = 1'b1; sw = 1'b1;
    clear_tallies();
    tick(); tick();
    check("reset_btn", btn, 1'b0);
    check("reset_left", left, 1'b0);
    check("reset_right", right, 1'b0);
    check("reset_err", err, 1'b0);
    rst = 1'b0;
    drive(1, 1, 1, 10);

    // Full clockwise detent
    clear_tallies();
    drive(1, 0, 1, 10);
    drive(0, 0, 1, 10);
    drive(0, 1, 1, 10);
    mark = edge_no;
    drive(1, 1, 1, 12);
    check_int("cw_right_count", n_right, 1);
    check_int("cw_right_latency", last_right - mark, 7);
    check_int("cw_left_count", n_left, 0);
    check_int("cw_err_count", n_err, 0);

    // Counter-clockwise detent
    clear_tallies();
    drive(0, 1, 1, 10);
    drive(0, 0, 1, 10);
    drive(1, 0, 1, 10);
    drive(1, 1, 1, 10);
    check_int("ccw_left_count", n_left, 1);
    check_int("ccw_right_count", n_right, 0);

    // Half step forward then back: no pulse
    clear_tallies();
    drive(1, 0, 1, 10);
    drive(0, 0, 1, 10);
    drive(1, 0, 1, 10);
    drive(1, 1, 1, 10);
    check_int("reversal_pulses", n_left + n_right + n_err, 0);

    // Switch glitch then real press
    clear_tallies();
    drive(1, 1, 0, 3);
    drive(1, 1, 1, 10);
    check_int("sw_glitch_btn", n_btn, 0);
    mark = edge_no;
    drive(1, 1, 0, 20);
    check_int("sw_press_btn", n_btn, 1);
    check_int("sw_press_latency", last_btn - mark, 7);
    drive(1, 1, 1, 15);
    check_int("sw_release_btn", n_btn, 1);

    // Illegal double-channel change
    clear_tallies();
    drive(0, 0, 1, 10);
    check_int("illegal_err", n_err, 1);
    check_int("illegal_rot", n_left + n_right, 0);
    drive(1, 1, 1, 12);

    // Reset mid-detent abandons progress
    clear_tallies();
    drive(1, 0, 1, 10);
    drive(0, 0, 1, 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 1, 1, 10);
    drive(1, 1, 1, 12);
    check_int("reset_mid_detent_rot", n_left + n_right, 0);

    // Press coinciding with the final clockwise step
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1, 1, 1, 5);
    clear_tallies();
    drive(1, 0, 1, 10);
    drive(0, 0, 1, 10);
    drive(0, 1, 1, 10);
    drive(1, 1, 0, 12);
    check_int("btn_right_same_cycle", n_both, 1);
    drive(1, 1, 1, 12);

    // Random stimulus against the model
    for (int k = 0; k < 120; k++) begin
      rst = ($urandom_range(0, 39) == 0);
      a = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      sw = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 12)) begin
        tick();
        rst = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
